frame_issuer: RTL and testbench
===============================

FRAME_ISSUER -- requirements
Module: frame_issuer

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 s_valid  input  1  upstream word valid.
REQ-004 s_data  input  9  upstream word.
REQ-005 s_mode  input  3  frame mode; sampled only with word 0 of a frame.
REQ-006 s_ready  output  1  upstream accept; a word transfers when s_valid && s_ready.
REQ-007 in_valid  output  1  to core; high for exactly 6 consecutive cycles per frame.
REQ-008 in_data  output  9  to core; frame word k on issue cycle k.
REQ-009 in_mode  output  3  to core; frame mode on issue cycle 0.
REQ-010 out_valid  input  1  from core; 6-cycle result burst.
REQ-011 frame_done  output  1  one-cycle pulse on normal frame completion.
REQ-012 latency  output  11  cycles from last issue cycle to first out_valid, for the last completed frame.
REQ-013 err_timeout  output  1  sticky; core never answered.
REQ-014 err_burst  output  1  sticky; core burst shorter than 6.

Function
REQ-015 The FSM SHALL have states FILL, GAP, ISSUE and WAIT; reset state is FILL.
REQ-016 FILL: s_ready=1; accepted words go to buf[0..5] in order via a 3-bit word index; s_mode latched with word 0.
REQ-017 The cycle after the 6th accepted word, the FSM SHALL enter GAP; s_ready=0 in all states except FILL.
REQ-018 GAP SHALL last exactly 2 cycles with in_valid=0, then enter ISSUE.
REQ-019 ISSUE cycle k (0..5) SHALL drive in_valid=1 and in_data=buf[k]; in_mode=latched mode at k=0 and 0 at k=1..5.
REQ-020 Outside ISSUE, in_valid, in_data and in_mode SHALL all be 0 (never X).
REQ-021 After ISSUE cycle 5, the FSM SHALL enter WAIT and clear an 11-bit wait counter and a 3-bit burst counter.
REQ-022 WAIT, out_valid=0 before any burst: the wait counter increments; on reaching 2000, err_timeout SHALL set and the FSM SHALL return to FILL with no frame_done.
REQ-023 WAIT, out_valid=1: the burst counter increments; on the first high cycle, latency SHALL load the wait counter value, saturated at 2047.
REQ-024 When the 6th consecutive out_valid=1 cycle is seen, frame_done SHALL pulse the next cycle and the FSM SHALL return to FILL.
REQ-025 If out_valid falls after 1-5 high cycles, err_burst SHALL set and the FSM SHALL return to FILL with no frame_done.
REQ-026 out_valid in FILL, GAP or ISSUE SHALL be ignored; it does not count toward the burst and does not affect error flags.
REQ-027 Errors do not block operation: the next frame SHALL fill normally after any error return.
REQ-028 The buffer SHALL be fully overwritten per frame; there is no partial-frame issue and no prefetch of the next frame during GAP, ISSUE or WAIT.
REQ-029 s_valid deasserted mid-fill SHALL stall the word index; the frame waits indefinitely with no timeout in FILL.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL enter FILL, clear the word index and all counters, and drive the following outputs the next cycle: s_ready=1, in_valid=0, in_data=0, in_mode=0, frame_done=0, latency=0, err_timeout=0, err_burst=0.
REQ-031 Reset mid-ISSUE or mid-WAIT SHALL abort the frame; no further in_valid cycles are issued and buffered data is discarded.

Verification
REQ-032 Basic frame: words 1..6 with mode 3'b101 back-to-back, core answers 3 cycles after the last issue with 6 high cycles -> 2 idle cycles, in_valid for 6 cycles, data 1..6, in_mode 5 then 0; latency=3; one frame_done pulse.
REQ-033 Stalled fill: s_valid toggled 1,0,1,0,... over 12 cycles -> exactly 6 words captured in order; GAP starts the cycle after the 6th transfer.
REQ-034 Timeout: core never asserts out_valid -> err_timeout=1 exactly 2000 WAIT cycles after ISSUE ends; s_ready=1 the next cycle; a following good frame completes with err_timeout still 1.
REQ-035 Short burst: out_valid high for 4 cycles then low -> err_burst=1, no frame_done, FSM in FILL.
REQ-036 Spurious out_valid during ISSUE, then a proper 6-cycle burst in WAIT -> frame_done pulses, no errors, latency counted from WAIT entry.
REQ-037 Reset at ISSUE cycle 2 -> in_valid=0 the next cycle, s_ready=1, all outputs at reset values.

Source files
------------

// File: rtl/frame_issuer.sv
`timescale 1ns/1ps
// Frame issuer: collects six upstream words, pauses for two idle cycles, issues the frame
// to the core over six cycles, then supervises the core's six-cycle result burst.
module frame_issuer (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [8:0]  s_data,
    input  logic [2:0]  s_mode,
    output logic        s_ready,
    output logic        in_valid,
    output logic [8:0]  in_data,
    output logic [2:0]  in_mode,
    input  logic        out_valid,
    output logic        frame_done,
    output logic [10:0] latency,
    output logic        err_timeout,
    output logic        err_burst
);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_GAP   = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam logic [10:0] TIMEOUT_LAST = 11'd1999;
    localparam logic [10:0] LAT_MAX      = 11'h7FF;

    logic [1:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        gap_q, gap_d;
    logic [10:0] wait_q, wait_d;
    logic [2:0]  burst_q, burst_d;
    logic [2:0]  mode_q, mode_d;
    logic [10:0] latency_q, latency_d;
    logic        err_timeout_q, err_timeout_d;
    logic        err_burst_q, err_burst_d;
    logic        frame_done_q, frame_done_d;
    logic [5:0]  wr_en;
    logic [8:0]  words [0:7];

    // Entries 6 and 7 read as zero so the 3-bit index never selects an undriven word.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_word
            if (gi < 6) begin : g_store
                logic [8:0] word_q;
                always_ff @(posedge clk) begin
                    if (wr_en[gi]) begin
                        word_q <= s_data;
                    end
                end
                assign words[gi] = word_q;
            end else begin : g_pad
                assign words[gi] = 9'd0;
            end
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        wait_d        = wait_q;
        burst_d       = burst_q;
        mode_d        = mode_q;
        latency_d     = latency_q;
        err_timeout_d = err_timeout_q;
        err_burst_d   = err_burst_q;
        frame_done_d  = 1'b0;
        wr_en         = 6'd0;
        case (state_q)
            ST_FILL: begin
                if (s_valid) begin
                    wr_en = 6'd1 << idx_q;
                    if (idx_q == 3'd0) begin
                        mode_d = s_mode;
                    end
                    if (idx_q == 3'd5) begin
                        idx_d   = 3'd0;
                        gap_d   = 1'b0;
                        state_d = ST_GAP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q) begin
                    idx_d   = 3'd0;
                    state_d = ST_ISSUE;
                end else begin
                    gap_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (idx_q == 3'd5) begin
                    idx_d   = 3'd0;
                    wait_d  = 11'd0;
                    burst_d = 3'd0;
                    state_d = ST_WAIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: begin
                // Latency counts the current WAIT cycle too, so it is the distance from the last issue cycle.
                if (out_valid) begin
                    burst_d = burst_q + 3'd1;
                    if (burst_q == 3'd0) begin
                        latency_d = (wait_q == LAT_MAX) ? LAT_MAX : wait_q + 11'd1;
                    end
                    if (burst_q == 3'd5) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_FILL;
                    end
                end else if (burst_q != 3'd0) begin
                    err_burst_d = 1'b1;
                    state_d     = ST_FILL;
                end else begin
                    wait_d = wait_q + 11'd1;
                    if (wait_q == TIMEOUT_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = ST_FILL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FILL;
            idx_q         <= 3'd0;
            gap_q         <= 1'b0;
            wait_q        <= 11'd0;
            burst_q       <= 3'd0;
            mode_q        <= 3'd0;
            latency_q     <= 11'd0;
            err_timeout_q <= 1'b0;
            err_burst_q   <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            wait_q        <= wait_d;
            burst_q       <= burst_d;
            mode_q        <= mode_d;
            latency_q     <= latency_d;
            err_timeout_q <= err_timeout_d;
            err_burst_q   <= err_burst_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign s_ready     = (state_q == ST_FILL);
    assign in_valid    = (state_q == ST_ISSUE);
    assign in_data     = in_valid ? words[idx_q] : 9'd0;
    assign in_mode     = (in_valid && idx_q == 3'd0) ? mode_q : 3'd0;
    assign frame_done  = frame_done_q;
    assign latency     = latency_q;
    assign err_timeout = err_timeout_q;
    assign err_burst   = err_burst_q;

endmodule

// File: tb/tb_frame_issuer.sv
`timescale 1ns/1ps
// Directed bench for frame_issuer: a cycle table for the basic frame plus
// hand-written sequences for stalls, errors and reset mid-frame.
module tb_frame_issuer;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [8:0]  s_data;
    logic [2:0]  s_mode;
    logic        s_ready;
    logic        in_valid;
    logic [8:0]  in_data;
    logic [2:0]  in_mode;
    logic        out_valid;
    logic        frame_done;
    logic [10:0] latency;
    logic        err_timeout;
    logic        err_burst;

    int n_cmp = 0;
    int n_bad = 0;

    frame_issuer dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_mode     (s_mode),
        .s_ready    (s_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .latency    (latency),
        .err_timeout(err_timeout),
        .err_burst  (err_burst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic [8:0] sd;
        logic [2:0] sm;
        logic       ov;
        logic       e_rdy;
        logic       e_iv;
        logic [8:0] e_id;
        logic [2:0] e_im;
        logic       e_fd;
    } vec_t;

    vec_t vecs [0:22];

    task automatic set_vec(input int i, input logic sv, input logic [8:0] sd, input logic [2:0] sm,
                           input logic ov, input logic e_rdy, input logic e_iv,
                           input logic [8:0] e_id, input logic [2:0] e_im, input logic e_fd);
        vecs[i] = '{sv, sd, sm, ov, e_rdy, e_iv, e_id, e_im, e_fd};
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs set before step() are sampled at its rising edge; outputs read after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_frame(input logic [8:0] base, input logic [2:0] mode);
        for (int k = 0; k < 6; k++) begin
            s_valid = 1'b1;
            s_data  = base + 9'(k);
            s_mode  = (k == 0) ? mode : 3'd7;
            step();
        end
        s_valid = 1'b0;
        s_data  = 9'd0;
        s_mode  = 3'd0;
    endtask

    // Waits (bounded) for ISSUE, checks the six issued words, ends on the first WAIT cycle.
    task automatic expect_issue(input logic [8:0] base, input logic [2:0] mode, input logic ov,
                                input int exp_wait, input string tag);
        int waited = 0;
        while (!in_valid && waited < 10) begin
            step();
            waited++;
        end
        check({tag, "_gap_len"}, waited, exp_wait);
        if (!in_valid) return;
        out_valid = ov;
        for (int k = 0; k < 6; k++) begin
            check({tag, "_in_valid"}, in_valid, 1);
            check({tag, "_in_data"}, in_data, base + 9'(k));
            check({tag, "_in_mode"}, in_mode, (k == 0) ? mode : 3'd0);
            step();
        end
        out_valid = 1'b0;
        check({tag, "_in_valid_after"}, in_valid, 0);
        check({tag, "_in_data_after"}, in_data, 0);
    endtask

    task automatic burst(input int n, input string tag);
        out_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            check({tag, "_no_early_done"}, frame_done, 0);
            step();
        end
        out_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 9'd0; s_mode = 3'd0; out_valid = 1'b0;

        //        i   sv  sd      sm  ov  rdy iv  id     im  fd
        set_vec(0,  1, 9'd1,   5, 0,  1,  0, 9'd0,  0,  0);
        set_vec(1,  1, 9'd2,   2, 0,  1,  0, 9'd0,  0,  0);
        set_vec(2,  1, 9'd3,   2, 0,  1,  0, 9'd0,  0,  0);
        set_vec(3,  1, 9'd4,   2, 0,  1,  0, 9'd0,  0,  0);
        set_vec(4,  1, 9'd5,   2, 0,  1,  0, 9'd0,  0,  0);
        set_vec(5,  1, 9'd6,   2, 0,  0,  0, 9'd0,  0,  0);
        set_vec(6,  1, 9'h1AA, 6, 0,  0,  0, 9'd0,  0,  0);
        set_vec(7,  1, 9'h1AA, 6, 0,  0,  1, 9'd1,  5,  0);
        set_vec(8,  1, 9'h1AA, 6, 0,  0,  1, 9'd2,  0,  0);
        set_vec(9,  1, 9'h1AA, 6, 0,  0,  1, 9'd3,  0,  0);
        set_vec(10, 1, 9'h1AA, 6, 0,  0,  1, 9'd4,  0,  0);
        set_vec(11, 1, 9'h1AA, 6, 0,  0,  1, 9'd5,  0,  0);
        set_vec(12, 1, 9'h1AA, 6, 0,  0,  1, 9'd6,  0,  0);
        set_vec(13, 1, 9'h1AA, 6, 0,  0,  0, 9'd0,  0,  0);
        set_vec(14, 1, 9'h1AA, 6, 0,  0,  0, 9'd0,  0,  0);
        set_vec(15, 1, 9'h1AA, 6, 0,  0,  0, 9'd0,  0,  0);
        set_vec(16, 0, 9'd0,   0, 1,  0,  0, 9'd0,  0,  0);
        set_vec(17, 0, 9'd0,   0, 1,  0,  0, 9'd0,  0,  0);
        set_vec(18, 0, 9'd0,   0, 1,  0,  0, 9'd0,  0,  0);
        set_vec(19, 0, 9'd0,   0, 1,  0,  0, 9'd0,  0,  0);
        set_vec(20, 0, 9'd0,   0, 1,  0,  0, 9'd0,  0,  0);
        set_vec(21, 0, 9'd0,   0, 1,  1,  0, 9'd0,  0,  1);
        set_vec(22, 0, 9'd0,   0, 0,  1,  0, 9'd0,  0,  0);

        step(); step();
        rst = 1'b0;
        check("rst_s_ready", s_ready, 1);
        check("rst_in_valid", in_valid, 0);
        check("rst_in_data", in_data, 0);
        check("rst_in_mode", in_mode, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_latency", latency, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_burst", err_burst, 0);

        // Basic frame, cycle by cycle
        for (int i = 0; i < 23; i++) begin
            s_valid = vecs[i].sv; s_data = vecs[i].sd; s_mode = vecs[i].sm; out_valid = vecs[i].ov;
            step();
            check($sformatf("basic%0d_s_ready", i), s_ready, vecs[i].e_rdy);
            check($sformatf("basic%0d_in_valid", i), in_valid, vecs[i].e_iv);
            check($sformatf("basic%0d_in_data", i), in_data, vecs[i].e_id);
            check($sformatf("basic%0d_in_mode", i), in_mode, vecs[i].e_im);
            check($sformatf("basic%0d_frame_done", i), frame_done, vecs[i].e_fd);
            $display("basic cycle %0d: rdy=%0d iv=%0d id=%0h im=%0d fd=%0d", i, s_ready, in_valid, in_data, in_mode, frame_done);
        end
        check("basic_latency", latency, 3);
        check("basic_err_timeout", err_timeout, 0);
        check("basic_err_burst", err_burst, 0);

        // Stalled fill: valid toggles, odd cycles carry junk that must be ignored
        for (int i = 0; i < 12; i++) begin
            s_valid = (i % 2 == 0);
            s_data  = (i % 2 == 0) ? 9'h40 + 9'(i / 2) : 9'h1FF;
            s_mode  = (i == 0) ? 3'd3 : 3'd6;
            step();
            check($sformatf("stall%0d_s_ready", i), s_ready, (i < 10) ? 1 : 0);
            check($sformatf("stall%0d_in_valid", i), in_valid, 0);
        end
        s_valid = 1'b0; s_data = 9'd0; s_mode = 3'd0;
        expect_issue(9'h40, 3'd3, 1'b0, 1, "stall");
        burst(6, "stall");
        check("stall_frame_done", frame_done, 1);
        check("stall_latency", latency, 1);
        $display("stalled fill frame: latency=%0d", latency);

        // Spurious out_valid during ISSUE, one idle WAIT cycle, then a proper burst
        fill_frame(9'h100, 3'd2);
        expect_issue(9'h100, 3'd2, 1'b1, 2, "spur");
        step();
        burst(6, "spur");
        check("spur_frame_done", frame_done, 1);
        check("spur_latency", latency, 2);
        check("spur_err_burst", err_burst, 0);
        check("spur_err_timeout", err_timeout, 0);
        $display("spurious frame: latency=%0d", latency);

        // Short burst of four
        fill_frame(9'h080, 3'd1);
        expect_issue(9'h080, 3'd1, 1'b0, 2, "short");
        burst(4, "short");
        check("short_err_before", err_burst, 0);
        step();
        check("short_err_burst", err_burst, 1);
        check("short_frame_done", frame_done, 0);
        check("short_s_ready", s_ready, 1);
        check("short_err_timeout", err_timeout, 0);
        $display("short burst: err_burst=%0d", err_burst);

        // Timeout: now at the first WAIT cycle
        fill_frame(9'h0C0, 3'd4);
        expect_issue(9'h0C0, 3'd4, 1'b0, 2, "tmo");
        repeat (1999) step();
        check("tmo_not_yet", err_timeout, 0);
        check("tmo_not_ready_yet", s_ready, 0);
        step();
        check("tmo_err_timeout", err_timeout, 1);
        check("tmo_s_ready", s_ready, 1);
        check("tmo_frame_done", frame_done, 0);
        $display("timeout: err_timeout=%0d", err_timeout);
        fill_frame(9'h010, 3'd7);
        expect_issue(9'h010, 3'd7, 1'b0, 2, "after_tmo");
        burst(6, "after_tmo");
        check("after_tmo_frame_done", frame_done, 1);
        check("after_tmo_latency", latency, 1);
        check("after_tmo_err_timeout", err_timeout, 1);
        $display("frame after timeout: done=%0d", frame_done);

        // Reset at ISSUE cycle 2
        fill_frame(9'h150, 3'd5);
        step(); step(); step(); step();
        check("rstmid_issue_k2_valid", in_valid, 1);
        check("rstmid_issue_k2_data", in_data, 9'h152);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_in_valid", in_valid, 0);
        check("rstmid_s_ready", s_ready, 1);
        check("rstmid_in_data", in_data, 0);
        check("rstmid_in_mode", in_mode, 0);
        check("rstmid_frame_done", frame_done, 0);
        check("rstmid_latency", latency, 0);
        check("rstmid_err_timeout", err_timeout, 0);
        check("rstmid_err_burst", err_burst, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("rstmid_idle%0d_in_valid", i), in_valid, 0);
            check($sformatf("rstmid_idle%0d_s_ready", i), s_ready, 1);
        end
        $display("reset mid-issue: in_valid=%0d s_ready=%0d", in_valid, s_ready);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
